// File: rtl/player_anim_fsm.sv
// player_anim_fsm
//   Per-player animation and motion controller. It arbitrates button inputs
//   and hit events into an action state, steps animation frames at a divided
//   frame_tick rate, and moves the player horizontally within the arena. It
//   also flags the window in which attack 1 can land a hit.
//
// Ports
//   clk           in   pixel/system clock
//   rst_n         in   asynchronous active-low reset
//   frame_tick    in   one-cycle pulse per video frame; gates every update
//   btn_left      in   move left (level, synchronised)
//   btn_right     in   move right (level, synchronised)
//   btn_atk1      in   request attack 1 (level)
//   btn_atk2      in   request attack 2 (level)
//   hit_in        in   opponent hit landed this frame (level)
//   anim_state    out  0=IDLE 1=MOVE 3=ATK1 4=ATK2 5=HIT
//   anim_frame    out  frame index within the current state
//   facing_right  out  1=right, 0=left
//   pos_x         out  sprite left edge, X_MIN..X_MAX
//   attack_active out  ATK1 frame inside [ATK1_ACT_LO, ATK1_ACT_HI]
//   busy          out  ATK1/ATK2/HIT, which lock out button input
module player_anim_fsm #(
  parameter int TICKS_PER_FRAME = 4,
  parameter int SPEED           = 2,
  parameter int X_INIT          = 100,
  parameter int X_MIN           = 0,
  parameter int X_MAX           = 514,
  parameter bit FACE_INIT       = 1'b1,
  parameter int IDLE_FRAMES     = 10,
  parameter int RUN_FRAMES      = 8,
  parameter int ATK1_FRAMES     = 18,
  parameter int ATK2_FRAMES     = 12,
  parameter int HIT_FRAMES      = 6,
  parameter int ATK1_ACT_LO     = 8,
  parameter int ATK1_ACT_HI     = 11
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_atk1,
  input  logic       btn_atk2,
  input  logic       hit_in,
  output logic [3:0] anim_state,
  output logic [5:0] anim_frame,
  output logic       facing_right,
  output logic [9:0] pos_x,
  output logic       attack_active,
  output logic       busy
);

  localparam int DIV_W = (TICKS_PER_FRAME > 1) ? $clog2(TICKS_PER_FRAME) : 1;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_MOVE = 4'd1,
    ST_ATK1 = 4'd3,
    ST_ATK2 = 4'd4,
    ST_HIT  = 4'd5
  } state_t;

  state_t             state, state_n;
  logic [5:0]         frame, frame_n;
  logic [DIV_W-1:0]   div, div_n;
  logic [9:0]         pos, pos_n;
  logic               facing, facing_n;

  state_t             target;
  logic               restart;
  logic               one_dir;
  logic               last_frame;
  logic               div_wrap;
  logic [5:0]         frame_cnt;
  logic signed [10:0] pos_calc;

  function automatic logic [5:0] count_of(input state_t s);
    case (s)
      ST_MOVE: count_of = 6'(RUN_FRAMES);
      ST_ATK1: count_of = 6'(ATK1_FRAMES);
      ST_ATK2: count_of = 6'(ATK2_FRAMES);
      ST_HIT:  count_of = 6'(HIT_FRAMES);
      default: count_of = 6'(IDLE_FRAMES);
    endcase
  endfunction

  always_comb begin
    busy          = (state == ST_ATK1) || (state == ST_ATK2) || (state == ST_HIT);
    attack_active = (state == ST_ATK1) &&
                    (frame >= 6'(ATK1_ACT_LO)) && (frame <= 6'(ATK1_ACT_HI));
  end

  always_comb begin
    state_n    = state;
    frame_n    = frame;
    div_n      = div;
    pos_n      = pos;
    facing_n   = facing;
    target     = state;
    restart    = 1'b0;
    pos_calc   = '0;
    one_dir    = btn_left ^ btn_right;
    frame_cnt  = count_of(state);
    last_frame = (frame >= frame_cnt - 6'd1);
    div_wrap   = (div == DIV_W'(TICKS_PER_FRAME - 1));

    // Pick the target state; restart=1 whenever the state changes (or HIT re-fires)
    if (hit_in) begin
      target  = ST_HIT;
      restart = 1'b1;
    end else if (busy) begin
      target  = state;
      restart = 1'b0;
    end else if (btn_atk1) begin
      target  = ST_ATK1;
      restart = 1'b1;
    end else if (btn_atk2) begin
      target  = ST_ATK2;
      restart = 1'b1;
    end else if (one_dir) begin
      target  = ST_MOVE;
      restart = (state != ST_MOVE);
    end else begin
      target  = ST_IDLE;
      restart = (state != ST_IDLE);
    end

    if (restart) begin
      state_n = target;
      frame_n = '0;
      div_n   = '0;
    end else if (div_wrap) begin
      div_n = '0;
      if (last_frame) begin
        // One-shot actions drop back to IDLE; loops just wrap
        frame_n = '0;
        if (busy) state_n = ST_IDLE;
      end else begin
        frame_n = frame + 6'd1;
      end
    end else begin
      div_n = div + DIV_W'(1);
    end

    if (!busy && one_dir) facing_n = btn_right;

    // Clamp in signed 11-bit so stepping left of 0 cannot wrap
    if (state_n == ST_MOVE) begin
      if (btn_right) pos_calc = $signed({1'b0, pos}) + $signed(11'(SPEED));
      else           pos_calc = $signed({1'b0, pos}) - $signed(11'(SPEED));
      if (pos_calc < $signed(11'(X_MIN)))      pos_n = 10'(X_MIN);
      else if (pos_calc > $signed(11'(X_MAX))) pos_n = 10'(X_MAX);
      else                                     pos_n = pos_calc[9:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      frame  <= '0;
      div    <= '0;
      pos    <= 10'(X_INIT);
      facing <= FACE_INIT;
    end else if (frame_tick) begin
      state  <= state_n;
      frame  <= frame_n;
      div    <= div_n;
      pos    <= pos_n;
      facing <= facing_n;
    end
  end

  assign anim_state   = state;
  assign anim_frame   = frame;
  assign facing_right = facing;
  assign pos_x        = pos;

endmodule
